// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester turning a valid/ready command stream into APB transfers
// One outstanding transfer; response held until consumed, with optional ACCESS timeout.
module apb_requester #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);
    localparam logic        TO_EN    = (TIMEOUT != 0);

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d, cnt_inc;
    logic                cmd_ready_q, cmd_ready_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    // Saturating so a wait-forever transfer never wraps back into a false timeout.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (TO_EN && (cnt_inc >= TO_LIMIT)) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake/strobe outputs are registered copies of the next-state decode.
        cmd_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - scoreboard bench for apb_requester with a randomized APB slave
module tb_apb_requester;

    localparam int TO = 4;

    logic       pclk = 1'b0;
    logic       preset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [7:0] paddr, pwdata, prdata;
    logic       psel, penable, pwrite, pready, pslverr;

    apb_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
        int         wait_n;
    } slv_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       to;
        int         acc;
    } exp_t;

    slv_t slv_q[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errs = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   n_done = 0;
    bit   mon_off = 1'b1;
    bit   hold_req = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a transfer that would need TO or more wait states is aborted after TO ACCESS cycles.
    function automatic exp_t model(input slv_t s);
        exp_t e;
        if (s.wait_n >= TO) begin
            e.rdata = 8'h00; e.err = 1'b1; e.to = 1'b1; e.acc = TO;
        end else begin
            e.rdata = s.write ? 8'h00 : s.rdata; e.err = s.err; e.to = 1'b0; e.acc = s.wait_n + 1;
        end
        return e;
    endfunction

    task automatic issue(input slv_t s);
        int tmo;
        exp_q.push_back(model(s));
        slv_q.push_back(s);
        cmd_valid = 1'b1;
        cmd_write = s.write;
        cmd_addr  = s.addr;
        cmd_wdata = s.wdata;
        tmo = 0;
        while (!cmd_ready && tmo < 300) begin
            @(negedge pclk);
            tmo++;
        end
        if (!cmd_ready) begin
            $display("FAIL accept_timeout: cmd_ready stuck low, got 0 expected 1");
            $fatal(1, "no command accept");
        end
        accept_cyc = cyc + 1;
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    function automatic slv_t mk(input logic w, input logic [7:0] a, input logic [7:0] wd,
                                input logic [7:0] rd, input logic e, input int wn);
        slv_t s;
        s.write = w; s.addr = a; s.wdata = wd; s.rdata = rd; s.err = e; s.wait_n = wn;
        return s;
    endfunction

    // APB slave: pops one config per ACCESS phase and holds pready low for wait_n cycles.
    initial begin : slave
        slv_t c;
        int   waited;
        bit   active;
        active = 1'b0; waited = 0;
        c = mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 0);
        pready = 1'b0; prdata = 8'h00; pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                active = 1'b0;
                pready = 1'b0;
            end else if (psel && penable) begin
                if (!active) begin
                    if (slv_q.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL slave_underflow: ACCESS with no pending command, got 1 expected 0");
                        c = mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1000);
                    end else begin
                        c = slv_q.pop_front();
                    end
                    active = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                end
                chk("paddr", 32'(paddr), 32'(c.addr));
                chk("pwrite", 32'(pwrite), 32'(c.write));
                if (c.write) chk("pwdata", 32'(pwdata), 32'(c.wdata));
                pready  = (waited == c.wait_n);
                prdata  = pready ? c.rdata : 8'($urandom);
                pslverr = pready ? c.err : 1'($urandom);
            end else begin
                if (psel) chk("setup_penable", 32'(penable), 32'd0);
                active = 1'b0;
                pready = 1'b0;
                prdata = 8'($urandom);
                pslverr = 1'($urandom);
            end
        end
    end

    initial begin : rsp_drv
        int low_cnt;
        low_cnt = 0;
        rsp_ready = 1'b1;
        forever begin
            @(negedge pclk);
            if (hold_req) begin
                low_cnt = 5;
                hold_req = 1'b0;
            end
            if (low_cnt > 0) begin
                rsp_ready = 1'b0;
                low_cnt--;
            end else if ($urandom_range(0, 15) == 0) begin
                low_cnt = 3;
                rsp_ready = 1'b0;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: compares the held response against the scoreboard head every cycle it is valid.
    initial begin : monitor
        int  acc_cnt;
        bit  seen;
        exp_t e;
        acc_cnt = 0; seen = 1'b0;
        forever begin
            @(negedge pclk);
            #1;
            if (preset || mon_off) begin
                acc_cnt = 0;
                seen = 1'b0;
            end else begin
                if (penable) acc_cnt++;
                if (psel) chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                if (rsp_valid) begin
                    chk("cmd_ready_resp", 32'(cmd_ready), 32'd0);
                    chk("psel_resp", 32'(psel), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL rsp_unexpected: rsp_valid with empty scoreboard, got 1 expected 0");
                    end else begin
                        e = exp_q[0];
                        if (!seen) begin
                            seen = 1'b1;
                            chk("access_cycles", 32'(acc_cnt), 32'(e.acc));
                            chk("rsp_latency", 32'(cyc - accept_cyc), 32'(e.acc + 1));
                        end
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            seen = 1'b0;
                            acc_cnt = 0;
                            n_done++;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int tmo;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_bits", {rsp_rdata, rsp_err, rsp_timeout}, 32'd0);
        preset = 1'b0;
        mon_off = 1'b0;
        @(negedge pclk);

        issue(mk(1'b1, 8'h04, 8'hA5, 8'h77, 1'b0, 0));
        issue(mk(1'b0, 8'h10, 8'h00, 8'h3C, 1'b0, 3));
        issue(mk(1'b0, 8'h22, 8'h00, 8'h5A, 1'b1, 0));
        issue(mk(1'b0, 8'h30, 8'h00, 8'hFF, 1'b0, 100));
        hold_req = 1'b1;
        issue(mk(1'b1, 8'h41, 8'h3E, 8'h00, 1'b1, 4));
        issue(mk(1'b1, 8'h42, 8'hC3, 8'h00, 1'b0, 2));

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            issue(mk(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 6)));
        end

        tmo = 0;
        while (exp_q.size() != 0 && tmo < 500) begin
            @(negedge pclk);
            tmo++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        chk("completed", 32'(n_done), 32'd206);

        issue(mk(1'b0, 8'h55, 8'h00, 8'h99, 1'b0, 20));
        tmo = 0;
        while (!penable && tmo < 20) begin
            @(negedge pclk);
            tmo++;
        end
        chk("reach_access", 32'(penable), 32'd1);
        mon_off = 1'b1;
        #2;
        preset = 1'b1;
        #1;
        chk("arst_psel", 32'(psel), 32'd0);
        chk("arst_penable", 32'(penable), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge pclk);
        exp_q.delete();
        slv_q.delete();
        preset = 1'b0;
        @(negedge pclk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_psel", 32'(psel), 32'd0);
        mon_off = 1'b0;

        issue(mk(1'b0, 8'h66, 8'h00, 8'h81, 1'b0, 1));
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 100) begin
            @(negedge pclk);
            tmo++;
        end
        chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
